truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus and response stage wrapped around a small combinational gate network under test, such as a 3-input NAND-built function.
- Upstream role: steps an N_IN-bit input vector through every combination 0..2^N_IN-1. Each vector is held for HOLD cycles.
- Downstream role: samples the network's single output once per vector and compares it against a parameterised expected truth table.
- Reports mismatch count, first failing vector, and pass/done status. Replaces hand-written #delay vector lists in unit benches.

Parameters:
- N_IN, 3, width of the driven input vector; number of vectors = 2^N_IN.
- HOLD, 50, cycles each vector is held (>= 2).
- SETTLE, 2, cycle offset within a hold at which f_in is sampled (1 <= SETTLE <= HOLD-1).
- EXPECT, 8'h3A, expected output table, 2^N_IN bits; bit i = expected f_in for vec == i. Default matches F = x ? ~y : z with vec = {x,y,z}.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a sweep; sampled in IDLE or DONE only.
- vec, output, N_IN, input vector driven to the network under test; registered.
- f_in, input, 1, output returned from the network under test.
- busy, output, 1, high while sweeping.
- sample_valid, output, 1, one-cycle pulse on each sample cycle.
- mismatch, output, 1, valid with sample_valid; 1 when f_in != EXPECT[vec].
- done, output, 1, level; high after sweep completes until next start or rst.
- pass, output, 1, meaningful when done = 1; 1 iff err_count == 0.
- err_count, output, N_IN+1, number of mismatching vectors; saturates at 2^N_IN.
- fail_idx, output, N_IN, index of first mismatching vector; 0 if none.

Behaviour:
- Reset (rst = 1 at a clock edge, any state, including mid-sweep):
  - state = IDLE.
  - vec, busy, sample_valid, mismatch, done, pass, err_count, fail_idx = 0.
  - Hold counter hcnt = 0.
  - rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE, start = 1:
  - Next cycle: state = RUN, busy = 1, vec = 0, hcnt = 0.
  - err_count, fail_idx, pass = 0. done stays 0.
- RUN:
  - hcnt increments each cycle, 0..HOLD-1.
  - Sample: when hcnt == SETTLE, f_in is compared to EXPECT[vec] combinationally. On the next edge:
    - sample_valid = 1 for exactly one cycle.
    - mismatch = result.
    - If mismatching: err_count += 1; fail_idx = vec if this is the first mismatch.
  - Vector advance: when hcnt == HOLD-1 and vec != 2^N_IN-1, vec increments on the next edge and hcnt returns to 0.
  - Each vector is therefore visible on vec for exactly HOLD cycles.
  - f_in is sampled SETTLE cycles after vec changes, so latency from vec change to sample is SETTLE cycles.
  - Completion: when hcnt == HOLD-1 and vec == 2^N_IN-1, next state = DONE.
    - busy = 0, done = 1, pass = (err_count == 0).
    - The last sample's effect on err_count is already included.
  - start is ignored in RUN.
- DONE:
  - vec holds its last value (2^N_IN-1). Results hold.
  - start = 1 behaves exactly as start in IDLE: done drops, counters clear, new sweep begins next cycle.
- Total sweep duration: 2^N_IN * HOLD cycles from the first RUN cycle to done = 1.
- Widths:
  - err_count is N_IN+1 bits, so the all-fail case reaches exactly 2^N_IN without wrap.
  - vec wraps never; the sweep terminates at the last vector.
- sample_valid and mismatch are 0 in every cycle except sample pulses.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep.
  - On the cycle its sample_valid pulse is asserted, state moves to DONE: busy = 0, done = 1, pass = 0, err_count = 1, fail_idx = failing vector.
  - vec holds the failing vector.
- Not defined: the sweep always covers all 2^N_IN vectors and counts every mismatch, as described above.

Test Plan:
1. Bench with HOLD = 4, SETTLE = 1, N_IN = 3, EXPECT = 8'h3A; correct x?~y:z model on f_in; pulse start -> vec steps 0..7, each held 4 cycles; 8 sample_valid pulses; done = 1 exactly 32 cycles after RUN entry; pass = 1, err_count = 0, fail_idx = 0.
2. Same bench, f_in tied 0 -> mismatches at vec 1, 3, 4, 5; err_count = 4, fail_idx = 1, pass = 0.
3. f_in = ~model -> err_count = 8 (no wrap in 4-bit field), fail_idx = 0, pass = 0.
4. rst asserted at cycle 10 of a sweep -> next cycle all outputs 0 and state IDLE; a new start gives a full clean sweep with pass = 1.
5. start pulsed during RUN -> ignored, sweep timing unchanged; start in DONE -> done drops next cycle, counters clear, vec = 0.
6. With SWEEP_STOP_ON_FAIL_EN defined and f_in tied 0 -> sweep stops at vec 1: done = 1, err_count = 1, fail_idx = 1, vec stays 1, only 2 sample_valid pulses seen.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Walks an N_IN-bit vector through every combination, samples the network output once per
// vector and scores it against EXPECT. Optional macro SWEEP_STOP_ON_FAIL_EN ends on first miss.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int HOLD   = 50,
    parameter int SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 8'h3A
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            f_in,
    output logic            busy,
    output logic            sample_valid,
    output logic            mismatch,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_idx
);
    localparam int NV = 1 << N_IN;
    localparam int HW = $clog2(HOLD);
    localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(NV - 1);
    localparam logic [HW-1:0]   HCNT_SMPL  = HW'(SETTLE);
    localparam logic [HW-1:0]   HCNT_LAST  = HW'(HOLD - 1);
    localparam logic [N_IN:0]   ERR_MAX    = (N_IN + 1)'(NV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            sample_valid_q, sample_valid_d;
    logic            mismatch_q, mismatch_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_count_q, err_count_d;
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;

    logic sample_now;
    logic hit;
    logic stop_now;

    function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    assign sample_now = (state_q == S_RUN) && (hcnt_q == HCNT_SMPL);
    assign hit        = (f_in != EXPECT[vec_q]);

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop_now = sample_now && hit;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        vec_d          = vec_q;
        busy_d         = busy_q;
        sample_valid_d = 1'b0;
        mismatch_d     = 1'b0;
        done_d         = done_q;
        pass_d         = pass_q;
        err_count_d    = err_count_q;
        fail_idx_d     = fail_idx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    busy_d      = 1'b1;
                    vec_d       = '0;
                    hcnt_d      = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    fail_idx_d  = '0;
                end
            end
            S_RUN: begin
                hcnt_d = hcnt_q + 1'b1;
                if (sample_now) begin
                    sample_valid_d = 1'b1;
                    mismatch_d     = hit;
                    if (hit) begin
                        err_count_d = sat_inc(err_count_q);
                        if (err_count_q == '0) fail_idx_d = vec_q;
                    end
                end
                // pass looks at err_count_d so a sample on the final hold cycle still counts
                if (stop_now || (hcnt_q == HCNT_LAST && vec_q == LAST_VEC)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                    hcnt_d  = '0;
                end else if (hcnt_q == HCNT_LAST) begin
                    vec_d  = vec_q + 1'b1;
                    hcnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            hcnt_q         <= '0;
            vec_q          <= '0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_count_q    <= '0;
            fail_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            vec_q          <= vec_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            mismatch_q     <= mismatch_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_count_q    <= err_count_d;
            fail_idx_q     <= fail_idx_d;
        end
    end

    assign vec          = vec_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign mismatch     = mismatch_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with HOLD=4, SETTLE=1 and a behavioural x?~y:z network.
module tb_truth_table_sweeper;
    localparam int N_IN   = 3;
    localparam int HOLD   = 4;
    localparam int SETTLE = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N_IN-1:0] vec;
    logic           f_in;
    logic           busy, sample_valid, mismatch, done, pass;
    logic [N_IN:0]  err_count;
    logic [N_IN-1:0] fail_idx;

    int f_mode = 0;   // 0: correct model, 1: tied low, 2: inverted model
    int n_chk  = 0;
    int n_bad  = 0;
    int cyc, pulses, mism, vec_err, pos_err;

    truth_table_sweeper #(
        .N_IN(N_IN), .HOLD(HOLD), .SETTLE(SETTLE), .EXPECT(8'h3A)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec(vec), .f_in(f_in),
        .busy(busy), .sample_valid(sample_valid), .mismatch(mismatch),
        .done(done), .pass(pass), .err_count(err_count), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    // Network under test: F = x ? ~y : z with vec = {x,y,z}
    always_comb begin
        logic model;
        model = vec[2] ? ~vec[1] : vec[0];
        case (f_mode)
            1:       f_in = 1'b0;
            2:       f_in = ~model;
            default: f_in = model;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic kick();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Called in the first RUN cycle; walks to done, optionally pulsing start mid-sweep.
    task automatic run_loop(input bit poke);
        cyc = 0; pulses = 0; mism = 0; vec_err = 0; pos_err = 0;
        forever begin
            if (sample_valid) pulses++;
            if (mismatch) mism++;
            if (sample_valid !== ((cyc % HOLD) == SETTLE + 1)) pos_err++;
            if (!done && vec !== N_IN'(cyc / HOLD)) vec_err++;
            if (done || cyc >= 200) break;
            start = (poke && cyc == 7);
            @(negedge clk); cyc++;
        end
        start = 1'b0;
    endtask

    task automatic chk_results(input string tg, input int e_cyc, input int e_pulses, input int e_mism,
                               input int e_pass, input int e_err, input int e_fail, input int e_vec);
        chk({tg, "_done"}, done, 1);
        chk({tg, "_cycles"}, cyc, e_cyc);
        chk({tg, "_pulses"}, pulses, e_pulses);
        chk({tg, "_mism_pulses"}, mism, e_mism);
        chk({tg, "_pulse_pos"}, pos_err, 0);
        chk({tg, "_vec_hold"}, vec_err, 0);
        chk({tg, "_busy"}, busy, 0);
        chk({tg, "_pass"}, pass, e_pass);
        chk({tg, "_err"}, err_count, e_err);
        chk({tg, "_fail_idx"}, fail_idx, e_fail);
        chk({tg, "_vec"}, vec, e_vec);
    endtask

    task automatic chk_all_zero(input string tg);
        chk({tg, "_vec"}, vec, 0);
        chk({tg, "_busy"}, busy, 0);
        chk({tg, "_sv"}, sample_valid, 0);
        chk({tg, "_mm"}, mismatch, 0);
        chk({tg, "_done"}, done, 0);
        chk({tg, "_pass"}, pass, 0);
        chk({tg, "_err"}, err_count, 0);
        chk({tg, "_fail"}, fail_idx, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // 1: correct network, clean sweep
        f_mode = 0;
        kick();
        chk("t1_busy0", busy, 1);
        chk("t1_vec0", vec, 0);
        run_loop(1'b0);
        chk_results("t1", 32, 8, 0, 1, 0, 0, 7);
        repeat (3) @(negedge clk);
        chk("t1_done_hold", done, 1);
        chk("t1_vec_hold", vec, 7);

        // 2: output tied low -> misses at 1,3,4,5
        f_mode = 1;
        kick();
        run_loop(1'b0);
`ifdef SWEEP_STOP_ON_FAIL_EN
        chk_results("t2", 6, 2, 1, 0, 1, 1, 1);
        repeat (3) @(negedge clk);
        chk("t2_vec_stays", vec, 1);
`else
        chk_results("t2", 32, 8, 4, 0, 4, 1, 7);
`endif

        // 5b: start from DONE clears results and restarts at vec 0
        f_mode = 2;
        kick();
        chk("t5_done_drop", done, 0);
        chk("t5_busy", busy, 1);
        chk("t5_vec", vec, 0);
        chk("t5_err_clr", err_count, 0);
        chk("t5_fail_clr", fail_idx, 0);
        chk("t5_pass_clr", pass, 0);
        // 3: inverted network -> every vector misses
        run_loop(1'b0);
`ifdef SWEEP_STOP_ON_FAIL_EN
        chk_results("t3", 2, 1, 1, 0, 1, 0, 0);
`else
        chk_results("t3", 32, 8, 8, 0, 8, 0, 7);
`endif

        // 4: reset mid-sweep, then a clean sweep
        f_mode = 0;
        kick();
        repeat (10) @(negedge clk);
        chk("t4_busy_mid", busy, 1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_all_zero("t4_rst");
        rst = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_vec", vec, 0);
        kick();
        run_loop(1'b0);
        chk_results("t4", 32, 8, 0, 1, 0, 0, 7);

        // 5a: start during RUN is ignored
        kick();
        run_loop(1'b1);
        chk_results("t5a", 32, 8, 0, 1, 0, 0, 7);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
